// File: rtl/ir_blob_decoder.sv
// IR-camera extended-mode report decoder: picks the first valid blob of four,
// smooths X/Y with a shift IIR and tracks loss of lock across frames.
module ir_blob_decoder #(
    parameter int unsigned SHIFT       = 2,
    parameter int unsigned LOST_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [95:0] frame_data,
    input  logic        frame_valid,
    output logic        busy,
    output logic        out_valid,
    output logic [9:0]  blob_x,
    output logic [9:0]  blob_y,
    output logic [3:0]  blob_size,
    output logic        blob_found,
    output logic [7:0]  drop_count
);

    localparam int unsigned AW = 10 + SHIFT;

    typedef enum logic [1:0] {IDLE, SCAN, FILTER, EMIT} state_t;

    state_t         state, state_nx;
    logic [1:0]     scan_idx;
    logic [95:0]    frame;
    logic           hit;
    logic [9:0]     hit_x, hit_y;
    logic [3:0]     hit_size;
    logic           tracking;
    logic [7:0]     miss;
    logic [AW-1:0]  acc_x, acc_y, acc_x_nx, acc_y_nx;

    logic [23:0]    cur;
    logic [9:0]     cur_x, cur_y;
    logic [3:0]     cur_size;
    logic           cur_ok;

    always_comb begin
        cur = frame[95:72];
        case (scan_idx)
            2'd0: cur = frame[95:72];
            2'd1: cur = frame[71:48];
            2'd2: cur = frame[47:24];
            2'd3: cur = frame[23:0];
            default: cur = frame[95:72];
        endcase
        cur_x    = {cur[5:4], cur[23:16]};
        cur_y    = {cur[7:6], cur[15:8]};
        cur_size = cur[3:0];
        cur_ok   = (cur_size != 4'hF) && (cur_y <= 10'd767);
    end

    // First lock loads the accumulator directly so the output jumps to the blob.
    always_comb begin
        if (!tracking) begin
            acc_x_nx = AW'(hit_x) << SHIFT;
            acc_y_nx = AW'(hit_y) << SHIFT;
        end else begin
            acc_x_nx = acc_x - (acc_x >> SHIFT) + AW'(hit_x);
            acc_y_nx = acc_y - (acc_y >> SHIFT) + AW'(hit_y);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        out_valid = (state == EMIT);
        case (state)
            IDLE:    if (frame_valid) state_nx = SCAN;
            SCAN:    if (scan_idx == 2'd3) state_nx = FILTER;
            FILTER:  state_nx = EMIT;
            EMIT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame      <= '0;
            scan_idx   <= '0;
            hit        <= 1'b0;
            hit_x      <= '0;
            hit_y      <= '0;
            hit_size   <= '0;
            tracking   <= 1'b0;
            miss       <= '0;
            acc_x      <= '0;
            acc_y      <= '0;
            blob_x     <= '0;
            blob_y     <= '0;
            blob_size  <= '0;
            blob_found <= 1'b0;
            drop_count <= '0;
        end else begin
            if (busy && frame_valid && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        frame    <= frame_data;
                        scan_idx <= '0;
                        hit      <= 1'b0;
                    end
                end
                SCAN: begin
                    scan_idx <= scan_idx + 2'd1;
                    if (!hit && cur_ok) begin
                        hit      <= 1'b1;
                        hit_x    <= cur_x;
                        hit_y    <= cur_y;
                        hit_size <= cur_size;
                    end
                end
                // Outputs are registered here so they are already valid during EMIT.
                FILTER: begin
                    if (hit) begin
                        acc_x      <= acc_x_nx;
                        acc_y      <= acc_y_nx;
                        blob_x     <= 10'(acc_x_nx >> SHIFT);
                        blob_y     <= 10'(acc_y_nx >> SHIFT);
                        blob_size  <= hit_size;
                        blob_found <= 1'b1;
                        tracking   <= 1'b1;
                        miss       <= '0;
                    end else if (32'(miss) + 32'd1 >= LOST_FRAMES) begin
                        miss       <= 8'(LOST_FRAMES);
                        blob_found <= 1'b0;
                        tracking   <= 1'b0;
                    end else begin
                        miss       <= miss + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_blob_decoder.sv
// Directed bench for ir_blob_decoder; expected outputs are queued at stimulus
// time and checked by an independent monitor on each out_valid.
module tb_ir_blob_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [95:0] frame_data = '0;
    logic        frame_valid = 1'b0;
    logic        busy, out_valid, blob_found;
    logic [9:0]  blob_x, blob_y;
    logic [3:0]  blob_size;
    logic [7:0]  drop_count;

    ir_blob_decoder #(.SHIFT(2), .LOST_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
        .busy(busy), .out_valid(out_valid), .blob_x(blob_x), .blob_y(blob_y),
        .blob_size(blob_size), .blob_found(blob_found), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int size;
        int found;
        int due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    localparam logic [23:0] NOBLOB = 24'hFFFFFF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", cyc, e.due);
                chk("blob_x", int'(blob_x), e.x);
                chk("blob_y", int'(blob_y), e.y);
                chk("blob_size", int'(blob_size), e.size);
                chk("blob_found", int'(blob_found), e.found);
            end
        end
    end

    function automatic logic [23:0] mk_blob(input int x, input int y, input int size);
        logic [9:0] xv, yv;
        logic [3:0] sv;
        xv = 10'(x);
        yv = 10'(y);
        sv = 4'(size);
        return {xv[7:0], yv[7:0], yv[9:8], xv[9:8], sv};
    endfunction

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input logic [95:0] f, input int ex, input int ey,
                             input int es, input int ef);
        exp_t e;
        @(negedge clk);
        frame_data  = f;
        frame_valid = 1'b1;
        e.x = ex; e.y = ey; e.size = es; e.found = ef; e.due = cyc + 6;
        q.push_back(e);
        @(negedge clk);
        frame_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_blob_x", int'(blob_x), 0);
        chk("rst_blob_y", int'(blob_y), 0);
        chk("rst_size", int'(blob_size), 0);
        chk("rst_found", int'(blob_found), 0);
        chk("rst_drop", int'(drop_count), 0);

        chk("mk_blob_encode", int'(mk_blob(356, 288, 3)), int'(24'h642053));

        // First lock: loads directly
        run_frame({24'h642053, NOBLOB, NOBLOB, NOBLOB}, 356, 288, 3, 1);
        // Blended: acc_x 1424-356+456 = 1524 -> 381
        run_frame({mk_blob(456, 288, 3), NOBLOB, NOBLOB, NOBLOB}, 381, 288, 3, 1);
        // Blob1 has y=800 (invalid), blob2 wins: acc_x 1153 -> 288, acc_y 884 -> 221
        run_frame({NOBLOB, mk_blob(5, 800, 2), mk_blob(10, 20, 7), NOBLOB}, 288, 221, 7, 1);
        // Three empty frames: lock drops on the third, values hold
        run_frame({4{NOBLOB}}, 288, 221, 7, 1);
        run_frame({4{NOBLOB}}, 288, 221, 7, 1);
        run_frame({4{NOBLOB}}, 288, 221, 7, 0);
        // Reload after loss, no blending
        run_frame({mk_blob(600, 100, 1), NOBLOB, NOBLOB, NOBLOB}, 600, 100, 1, 1);
        chk("drop_before_flood", int'(drop_count), 0);

        // Continuous strobe: accepted every 7 cycles, 257 drops saturate at 255
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            frame_data  = {mk_blob(600, 100, 1), NOBLOB, NOBLOB, NOBLOB};
            frame_valid = 1'b1;
            if (i % 7 == 0) begin
                e.x = 600; e.y = 100; e.size = 1; e.found = 1; e.due = cyc + 6;
                q.push_back(e);
            end
        end
        @(negedge clk);
        frame_valid = 1'b0;
        wait_drain();
        chk("drop_saturated", int'(drop_count), 255);

        // Reset mid-SCAN aborts the frame
        @(negedge clk);
        frame_data  = {mk_blob(100, 50, 4), NOBLOB, NOBLOB, NOBLOB};
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        @(negedge clk);
        chk("mid_scan_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_drop", int'(drop_count), 0);
        chk("abort_found", int'(blob_found), 0);
        chk("abort_blob_x", int'(blob_x), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("queue_empty_end", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
